// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_CHK_HIGH,
        S_HIGH,
        S_CHK_LOW
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser for an asynchronous pad input; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_reg;
    logic q_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg <= 1'b0;
            q_reg  <= 1'b0;
        end else begin
            s1_reg <= d;
            q_reg  <= s1_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronise the pad, then accept a level change only
// after it has been seen stable for DEBOUNCE_CYCLES+1 consecutive edges.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_clean,
    output logic bouncing
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             clean_reg;
    logic             clean_next;
    logic             bouncing_reg;
    logic             bouncing_next;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_LOW;
            cnt_reg      <= '0;
            clean_reg    <= 1'b0;
            bouncing_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            clean_reg    <= clean_next;
            bouncing_reg <= bouncing_next;
        end
    end

    // Counter is cleared on every transition and in the stable states, so it
    // restarts from 0 whenever qualification begins again.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            S_LOW: begin
                if (btn_sync) state_next = S_CHK_HIGH;
            end
            S_CHK_HIGH: begin
                if (!btn_sync)                  state_next = S_LOW;
                else if (cnt_reg == CNT_LAST)   state_next = S_HIGH;
                else                            cnt_next   = cnt_reg + CNT_W'(1);
            end
            S_HIGH: begin
                if (!btn_sync) state_next = S_CHK_LOW;
            end
            S_CHK_LOW: begin
                if (btn_sync)                   state_next = S_HIGH;
                else if (cnt_reg == CNT_LAST)   state_next = S_LOW;
                else                            cnt_next   = cnt_reg + CNT_W'(1);
            end
            default: begin
                state_next = S_LOW;
            end
        endcase
    end

    // Outputs decode the next state so they line up with the state register.
    always_comb begin
        clean_next    = (state_next == S_HIGH)     || (state_next == S_CHK_LOW);
        bouncing_next = (state_next == S_CHK_HIGH) || (state_next == S_CHK_LOW);
    end

    assign btn_clean = clean_reg;
    assign bouncing  = bouncing_reg;

endmodule
